// File: rtl/svc_rv_stage_wb_seq.sv
// Writeback stage: selects the result source, registers the regfile write, counts retires and
// cycles, and parks in HALT after an EBREAK or an upstream trap until resume.
module svc_rv_stage_wb_seq #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NSRC  = 6,
    parameter int unsigned CNT_W = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [$clog2(NSRC)-1:0]       in_sel,
    input  logic [NSRC*XLEN-1:0]          in_data,
    input  logic [4:0]                    in_rd,
    input  logic                          in_reg_write,
    input  logic [31:0]                   in_instr,
    input  logic                          in_trap,
    input  logic                          resume,
    output logic                          rd_wen,
    output logic [4:0]                    rd_addr,
    output logic [XLEN-1:0]               rd_data,
    output logic                          halted,
    output logic [1:0]                    halt_cause,
    output logic                          retired,
    output logic [CNT_W-1:0]              instret,
    output logic [CNT_W-1:0]              cycles
);

    localparam int unsigned SelW     = $clog2(NSRC);
    localparam logic [31:0] Ebreak   = 32'h0010_0073;
    localparam logic [1:0]  CauseNone = 2'd0;
    localparam logic [1:0]  CauseEbrk = 2'd1;
    localparam logic [1:0]  CauseTrap = 2'd2;

    typedef enum logic {StRun, StHalt} state_e;

    state_e           state_q, state_d;
    logic             rd_wen_q, rd_wen_d;
    logic [4:0]       rd_addr_q, rd_addr_d;
    logic [XLEN-1:0]  rd_data_q, rd_data_d;
    logic [1:0]       halt_cause_q, halt_cause_d;
    logic             retired_q, retired_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;

    logic [XLEN-1:0]  sel_data;
    logic             accept;

    // Out-of-range selects match no source and fall through to zero.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < int'(NSRC); k++) begin
            if (in_sel == SelW'(k)) begin
                sel_data = in_data[k*XLEN +: XLEN];
            end
        end
    end

    assign accept = in_valid && (state_q == StRun);

    always_comb begin
        state_d      = state_q;
        rd_wen_d     = 1'b0;
        rd_addr_d    = rd_addr_q;
        rd_data_d    = rd_data_q;
        halt_cause_d = halt_cause_q;
        retired_d    = 1'b0;
        instret_d    = instret_q;
        cycles_d     = cycles_q + 1'b1;

        if (accept) begin
            rd_addr_d = in_rd;
            rd_data_d = sel_data;
            // A trap outranks EBREAK: no write, no retire.
            if (in_trap) begin
                halt_cause_d = CauseTrap;
                state_d      = StHalt;
            end else begin
                retired_d = 1'b1;
                instret_d = instret_q + 1'b1;
                rd_wen_d  = in_reg_write && (in_rd != 5'd0);
                if (in_instr == Ebreak) begin
                    halt_cause_d = CauseEbrk;
                    state_d      = StHalt;
                end
            end
        end else if ((state_q == StHalt) && resume) begin
            state_d      = StRun;
            halt_cause_d = CauseNone;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StRun;
            rd_wen_q     <= 1'b0;
            rd_addr_q    <= '0;
            rd_data_q    <= '0;
            halt_cause_q <= CauseNone;
            retired_q    <= 1'b0;
            instret_q    <= '0;
            cycles_q     <= '0;
        end else begin
            state_q      <= state_d;
            rd_wen_q     <= rd_wen_d;
            rd_addr_q    <= rd_addr_d;
            rd_data_q    <= rd_data_d;
            halt_cause_q <= halt_cause_d;
            retired_q    <= retired_d;
            instret_q    <= instret_d;
            cycles_q     <= cycles_d;
        end
    end

    assign in_ready   = (state_q == StRun);
    assign halted     = (state_q == StHalt);
    assign rd_wen     = rd_wen_q;
    assign rd_addr    = rd_addr_q;
    assign rd_data    = rd_data_q;
    assign halt_cause = halt_cause_q;
    assign retired    = retired_q;
    assign instret    = instret_q;
    assign cycles     = cycles_q;

endmodule

// File: tb/tb_svc_rv_stage_wb_seq.sv
// Directed bench for svc_rv_stage_wb_seq: a default instance plus a CNT_W=32 instance sharing
// the same stimulus for the instret wrap case.
module tb_svc_rv_stage_wb_seq;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NSRC = 6;
    localparam logic [31:0] Ebreak = 32'h0010_0073;
    localparam logic [31:0] Nop    = 32'h0000_0013;

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           in_sel;
    logic [NSRC*XLEN-1:0] in_data;
    logic [4:0]           in_rd;
    logic                 in_reg_write;
    logic [31:0]          in_instr;
    logic                 in_trap;
    logic                 resume;
    logic                 rd_wen;
    logic [4:0]           rd_addr;
    logic [XLEN-1:0]      rd_data;
    logic                 halted;
    logic [1:0]           halt_cause;
    logic                 retired;
    logic [63:0]          instret;
    logic [63:0]          cycles;

    logic                 in_ready32;
    logic                 rd_wen32;
    logic [4:0]           rd_addr32;
    logic [XLEN-1:0]      rd_data32;
    logic                 halted32;
    logic [1:0]           halt_cause32;
    logic                 retired32;
    logic [31:0]          instret32;
    logic [31:0]          cycles32;

    int unsigned n_checks;
    int unsigned n_pass;
    logic [63:0] cyc_exp;

    svc_rv_stage_wb_seq #(.XLEN(XLEN), .NSRC(NSRC), .CNT_W(64)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
        .in_data(in_data), .in_rd(in_rd), .in_reg_write(in_reg_write), .in_instr(in_instr),
        .in_trap(in_trap), .resume(resume), .rd_wen(rd_wen), .rd_addr(rd_addr),
        .rd_data(rd_data), .halted(halted), .halt_cause(halt_cause), .retired(retired),
        .instret(instret), .cycles(cycles)
    );

    svc_rv_stage_wb_seq #(.XLEN(XLEN), .NSRC(NSRC), .CNT_W(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32), .in_sel(in_sel),
        .in_data(in_data), .in_rd(in_rd), .in_reg_write(in_reg_write), .in_instr(in_instr),
        .in_trap(in_trap), .resume(resume), .rd_wen(rd_wen32), .rd_addr(rd_addr32),
        .rd_data(rd_data32), .halted(halted32), .halt_cause(halt_cause32),
        .retired(retired32), .instret(instret32), .cycles(cycles32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rst) cyc_exp = 64'd0;
        else     cyc_exp = cyc_exp + 64'd1;
    endtask

    task automatic beat(input logic [2:0] sel, input logic [4:0] rd, input logic rw,
                        input logic [31:0] instr, input logic trap);
        in_valid     = 1'b1;
        in_sel       = sel;
        in_rd        = rd;
        in_reg_write = rw;
        in_instr     = instr;
        in_trap      = trap;
        tick();
        in_valid     = 1'b0;
    endtask

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        cyc_exp      = 64'd0;
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_sel       = 3'd0;
        in_rd        = 5'd0;
        in_reg_write = 1'b0;
        in_instr     = Nop;
        in_trap      = 1'b0;
        resume       = 1'b0;
        for (int k = 0; k < int'(NSRC); k++) begin
            in_data[k*XLEN +: XLEN] = 32'h1000_0000 + k;
        end
        in_data[2*XLEN +: XLEN] = 32'hDEAD_BEEF;

        tick();
        tick();
        check("rst_rd_wen", {63'd0, rd_wen}, 64'd0);
        check("rst_rd_addr", {59'd0, rd_addr}, 64'd0);
        check("rst_rd_data", {32'd0, rd_data}, 64'd0);
        check("rst_retired", {63'd0, retired}, 64'd0);
        check("rst_halted", {63'd0, halted}, 64'd0);
        check("rst_cause", {62'd0, halt_cause}, 64'd0);
        check("rst_instret", instret, 64'd0);
        check("rst_cycles", cycles, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);

        rst = 1'b0;
        tick();
        check("cycles_first", cycles, 64'd1);
        check("ready_first", {63'd0, in_ready}, 64'd1);

        // Source 2 into x5.
        beat(3'd2, 5'd5, 1'b1, Nop, 1'b0);
        check("b1_wen", {63'd0, rd_wen}, 64'd1);
        check("b1_addr", {59'd0, rd_addr}, 64'd5);
        check("b1_data", {32'd0, rd_data}, 64'hDEAD_BEEF);
        check("b1_retired", {63'd0, retired}, 64'd1);
        check("b1_instret", instret, 64'd1);

        tick();
        check("idle_wen", {63'd0, rd_wen}, 64'd0);
        check("idle_retired", {63'd0, retired}, 64'd0);
        check("idle_addr_hold", {59'd0, rd_addr}, 64'd5);
        check("idle_data_hold", {32'd0, rd_data}, 64'hDEAD_BEEF);
        check("idle_instret", instret, 64'd1);

        // x0 destination retires without a write.
        beat(3'd4, 5'd0, 1'b1, Nop, 1'b0);
        check("x0_wen", {63'd0, rd_wen}, 64'd0);
        check("x0_retired", {63'd0, retired}, 64'd1);
        check("x0_data", {32'd0, rd_data}, 64'h1000_0004);
        check("x0_instret", instret, 64'd2);

        beat(3'd7, 5'd3, 1'b1, Nop, 1'b0);
        check("sel7_wen", {63'd0, rd_wen}, 64'd1);
        check("sel7_data", {32'd0, rd_data}, 64'd0);
        check("sel7_instret", instret, 64'd3);

        beat(3'd0, 5'd9, 1'b0, Nop, 1'b0);
        check("norw_wen", {63'd0, rd_wen}, 64'd0);
        check("norw_data", {32'd0, rd_data}, 64'h1000_0000);
        check("norw_retired", {63'd0, retired}, 64'd1);
        check("norw_instret", instret, 64'd4);
        check("cycles_run", cycles, cyc_exp);

        // EBREAK retires and halts.
        beat(3'd1, 5'd0, 1'b0, Ebreak, 1'b0);
        check("ebrk_retired", {63'd0, retired}, 64'd1);
        check("ebrk_halted", {63'd0, halted}, 64'd1);
        check("ebrk_cause", {62'd0, halt_cause}, 64'd1);
        check("ebrk_ready", {63'd0, in_ready}, 64'd0);
        check("ebrk_instret", instret, 64'd5);

        in_valid     = 1'b1;
        in_sel       = 3'd3;
        in_rd        = 5'd7;
        in_reg_write = 1'b1;
        in_instr     = Nop;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("halt_wen", {63'd0, rd_wen}, 64'd0);
            check("halt_retired", {63'd0, retired}, 64'd0);
            check("halt_instret", instret, 64'd5);
        end
        check("halt_addr_hold", {59'd0, rd_addr}, 64'd0);
        check("halt_cycles", cycles, cyc_exp);

        in_valid = 1'b0;
        resume   = 1'b1;
        tick();
        resume   = 1'b0;
        check("resume_halted", {63'd0, halted}, 64'd0);
        check("resume_cause", {62'd0, halt_cause}, 64'd0);
        check("resume_ready", {63'd0, in_ready}, 64'd1);

        // Trap on an EBREAK word with a write request.
        beat(3'd2, 5'd6, 1'b1, Ebreak, 1'b1);
        check("trap_wen", {63'd0, rd_wen}, 64'd0);
        check("trap_retired", {63'd0, retired}, 64'd0);
        check("trap_cause", {62'd0, halt_cause}, 64'd2);
        check("trap_halted", {63'd0, halted}, 64'd1);
        check("trap_instret", instret, 64'd5);

        // Reset while halted with a beat on the input.
        in_valid = 1'b1;
        in_trap  = 1'b0;
        rst      = 1'b1;
        tick();
        check("rst2_wen", {63'd0, rd_wen}, 64'd0);
        check("rst2_addr", {59'd0, rd_addr}, 64'd0);
        check("rst2_data", {32'd0, rd_data}, 64'd0);
        check("rst2_retired", {63'd0, retired}, 64'd0);
        check("rst2_cause", {62'd0, halt_cause}, 64'd0);
        check("rst2_halted", {63'd0, halted}, 64'd0);
        check("rst2_instret", instret, 64'd0);
        check("rst2_cycles", cycles, 64'd0);
        in_valid = 1'b0;
        rst      = 1'b0;
        tick();
        check("rst2_ready", {63'd0, in_ready}, 64'd1);
        check("rst2_cycles1", cycles, 64'd1);

        // 32-bit instret wraps from all-ones to zero.
        force dut32.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut32.instret_q;
        beat(3'd0, 5'd1, 1'b1, Nop, 1'b0);
        check("wrap32_instret", {32'd0, instret32}, 64'd0);
        check("wrap32_retired", {63'd0, retired32}, 64'd1);
        check("wrap64_instret", instret, 64'd1);
        check("cycles32", {32'd0, cycles32}, {32'd0, cyc_exp[31:0]});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
